// File: rtl/scie_pkg.sv
// scie_pkg: opcodes, command/state encodings and complex operand type for the SCIE issue sequencer.
package scie_pkg;
    localparam logic [31:0] INSN_LOAD = 32'h0000_000B;
    localparam logic [31:0] INSN_PUSH = 32'h0000_002B;
    localparam logic [31:0] INSN_READ = 32'h0000_005B;
    localparam int CPLX_W = 16;
    typedef enum logic {
        OP_LOAD   = 1'b0,
        OP_SAMPLE = 1'b1
    } cmd_op_e;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_COEF = 3'd1,
        S_PUSH = 3'd2,
        S_GAP  = 3'd3,
        S_READ = 3'd4,
        S_WAIT = 3'd5,
        S_OUT  = 3'd6
    } state_e;
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;
endpackage

// File: rtl/scie_issue_sequencer.sv
// scie_issue_sequencer: issues load/push/read SCIE instructions for queued commands and returns the complex result.
module scie_issue_sequencer
    import scie_pkg::*;
#(
    parameter int W      = 16,
    parameter int NTAPS  = 5,
    parameter int GAP    = 1,
    parameter int RD_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic signed [W-1:0] cmd_real,
    input  logic signed [W-1:0] cmd_imag,
    input  logic [31:0]         cmd_idx,
    output logic                scie_valid,
    output logic [31:0]         scie_insn,
    output logic signed [W-1:0] scie_rs1_real,
    output logic signed [W-1:0] scie_rs1_imag,
    output logic [31:0]         scie_rs2,
    input  logic signed [W-1:0] scie_rd_real,
    input  logic signed [W-1:0] scie_rd_imag,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [W-1:0] res_real,
    output logic signed [W-1:0] res_imag,
    output logic                err,
    output logic                busy
);
    localparam int CMAX  = (GAP > RD_LAT) ? GAP : RD_LAT;
    localparam int CNT_W = $clog2(CMAX + 1);

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic signed [W-1:0] op_re, op_im;
    logic [31:0]        op_idx;
    logic               st_coef, st_push, st_read;

    assign st_coef    = state == S_COEF;
    assign st_push    = state == S_PUSH;
    assign st_read    = state == S_READ;
    assign cmd_ready  = state == S_IDLE;
    assign busy       = state != S_IDLE;
    assign res_valid  = state == S_OUT;
    assign scie_valid = st_coef || st_push || st_read;
    assign scie_insn  = st_coef ? INSN_LOAD : st_push ? INSN_PUSH : st_read ? INSN_READ : 32'd0;
    assign scie_rs1_real = (st_coef || st_push) ? op_re : '0;
    assign scie_rs1_imag = (st_coef || st_push) ? op_im : '0;
    assign scie_rs2   = st_coef ? op_idx : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_re    <= '0;
            op_im    <= '0;
            op_idx   <= '0;
            res_real <= '0;
            res_imag <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_re  <= cmd_real;
                    op_im  <= cmd_imag;
                    op_idx <= cmd_idx;
                    if (cmd_op == OP_SAMPLE) state <= S_PUSH;
                    else if (cmd_idx < 32'(NTAPS)) state <= S_COEF;
                    else err <= 1'b1;
                end
                S_COEF: state <= S_IDLE;
                S_PUSH: begin
                    state <= (GAP == 0) ? S_READ : S_GAP;
                    cnt   <= CNT_W'((GAP > 0) ? GAP - 1 : 0);
                end
                S_GAP: if (cnt == '0) state <= S_READ; else cnt <= cnt - 1'b1;
                S_READ: begin
                    state <= S_WAIT;
                    cnt   <= CNT_W'(RD_LAT - 1);
                end
                // the final WAIT cycle is the one in which the unit's read data is valid
                S_WAIT: if (cnt == '0) begin
                    state    <= S_OUT;
                    res_real <= scie_rd_real;
                    res_imag <= scie_rd_imag;
                end else cnt <= cnt - 1'b1;
                S_OUT: if (res_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
